game_flow_ctrl: RTL

//  Parametrised screen/menu sequencer: TITLE -> MENU -> GAME (-> PAUSE) with debounced key input,
//  an N-entry wrap-around menu cursor, a one-cycle start pulse and per-slot menu-icon codes for the renderer.

---
 rtl/game_flow_pkg.sv | 25 ++
 rtl/key_press_detect.sv | 56 +++++
 rtl/game_flow_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/game_flow_pkg.sv
// Shared screen encodings and background colours for the game flow sequencer.
package game_flow_pkg;

   localparam logic [1:0] SCR_TITLE = 2'b00;
   localparam logic [1:0] SCR_MENU  = 2'b01;
   localparam logic [1:0] SCR_GAME  = 2'b10;
   localparam logic [1:0] SCR_PAUSE = 2'b11;

   localparam logic [11:0] BG_TITLE = 12'h077;
   localparam logic [11:0] BG_MENU  = 12'h770;
   localparam logic [11:0] BG_GAME  = 12'h070;
   localparam logic [11:0] BG_PAUSE = 12'h777;

   function automatic logic [11:0] bg_of(input logic [1:0] scr);
      logic [11:0] bg;
      case (scr)
         SCR_MENU:  bg = BG_MENU;
         SCR_GAME:  bg = BG_GAME;
         SCR_PAUSE: bg = BG_PAUSE;
         default:   bg = BG_TITLE;
      endcase
      return bg;
   endfunction

endpackage

// File: rtl/key_press_detect.sv
// One debounced push button: 2-FF synchroniser, stability counter, one-cycle press pulse.
module key_press_detect #(
   parameter int DEB_CYC = 250000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             state_q;
   logic             armed_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;
   logic             eff_level;

   // Until a debounced release has been seen the key is treated as held, so a
   // key held through reset cannot produce a press.
   assign eff_level = state_q & armed_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= 1'b1;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == eff_level) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= sync2_q;
            if (sync2_q) begin
               armed_q <= 1'b1;
            end else begin
               press_q <= 1'b1;
            end
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Screen/menu sequencer TITLE -> MENU -> GAME with wrap-around cursor and icon codes.
// Optional PAUSE screen enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int              N_OPT      = 3,
   parameter int              CODE_W     = 10,
   parameter int              DEB_CYC    = 250000,
   parameter logic [CODE_W-1:0] CODE_SEL   = 10'h0EB,
   parameter logic [CODE_W-1:0] CODE_UNSEL = 10'h0AA,
   parameter logic [CODE_W-1:0] CODE_IDLE  = 10'h18C,
   localparam int             SEL_W      = (N_OPT > 1) ? $clog2(N_OPT) : 1
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic [3:0]                KEY,
   input  logic                      gameover,
   output logic [1:0]                screen,
   output logic [11:0]               background,
   output logic                      start,
   output logic [SEL_W-1:0]          sel,
   output logic [N_OPT*CODE_W-1:0]   icon_codes
);

   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_OPT - 1);

   logic [3:0]        press;
   logic [1:0]        screen_q, screen_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              start_q, start_d;
   logic [11:0]       bg_q;
   logic [CODE_W-1:0] icon_q [N_OPT];

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_press_detect #(.DEB_CYC(DEB_CYC)) u_key (
         .CLOCK_50 (CLOCK_50),
         .reset    (reset),
         .key_n    (KEY[k]),
         .press    (press[k])
      );
   end

   // Exactly one action per cycle; in MENU start outranks cursor moves.
   always_comb begin
      screen_d = screen_q;
      sel_d    = sel_q;
      start_d  = 1'b0;
      case (screen_q)
         SCR_TITLE: begin
            if (|press) screen_d = SCR_MENU;
         end
         SCR_MENU: begin
            if (press[2]) begin
               screen_d = SCR_GAME;
               start_d  = 1'b1;
            end else if (press[0]) begin
               sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
            end else if (press[1]) begin
               sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
            end
         end
         SCR_GAME: begin
            if (gameover) begin
               screen_d = SCR_MENU;
`ifdef GAME_PAUSE_EN
            end else if (press[3]) begin
               screen_d = SCR_PAUSE;
`endif
            end
         end
`ifdef GAME_PAUSE_EN
         SCR_PAUSE: begin
            if (press[3]) screen_d = SCR_GAME;
         end
`endif
         default: screen_d = SCR_TITLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         screen_q <= SCR_TITLE;
         sel_q    <= '0;
         start_q  <= 1'b0;
         bg_q     <= BG_TITLE;
      end else begin
         screen_q <= screen_d;
         sel_q    <= sel_d;
         start_q  <= start_d;
         bg_q     <= bg_of(screen_d);
      end
   end

   // Icons follow the registered screen/cursor, so they trail them by one cycle.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < N_OPT; i++) icon_q[i] <= CODE_IDLE;
      end else begin
         for (int i = 0; i < N_OPT; i++) begin
            if (screen_q != SCR_MENU)        icon_q[i] <= CODE_IDLE;
            else if (sel_q == SEL_W'(i))     icon_q[i] <= CODE_SEL;
            else                             icon_q[i] <= CODE_UNSEL;
         end
      end
   end

   for (genvar g = 0; g < N_OPT; g++) begin : g_icon
      assign icon_codes[g*CODE_W +: CODE_W] = icon_q[g];
   end

   assign screen     = screen_q;
   assign background = bg_q;
   assign start      = start_q;
   assign sel        = sel_q;

endmodule
